// File: rtl/regfile_pkg.sv
// Shared constants for the PC3 register file slice.
package regfile_pkg;
  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/decoder_5_32.sv
// 5-to-32 one-hot decoder used for the write index and both read indices.
module decoder_5_32
  import regfile_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] sel,
  output logic [NUM_REGS-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/register_32.sv
// 32-bit storage register with load enable and synchronous clear.
module register_32
  import regfile_pkg::*;
(
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Clear wins over a simultaneous load.
  always_ff @(posedge clock) begin
    if (ctrl_reset)
      q <= '0;
    else if (enable)
      q <= d;
  end

endmodule

// File: rtl/regfile.sv
// 32 x 32 register file: one write port, two combinational read ports, r0 reads zero.
module regfile
  import regfile_pkg::*;
(
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);

  logic [NUM_REGS-1:0]   wr_dec;
  logic [NUM_REGS-1:0]   rd_dec_a;
  logic [NUM_REGS-1:0]   rd_dec_b;
  logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
  logic                  unused_wr_zero;

  decoder_5_32 u_dec_wr (.sel(ctrl_writeReg), .onehot(wr_dec));
  decoder_5_32 u_dec_a  (.sel(ctrl_readRegA), .onehot(rd_dec_a));
  decoder_5_32 u_dec_b  (.sel(ctrl_readRegB), .onehot(rd_dec_b));

  // r0 has no storage, so its write strobe goes nowhere.
  assign unused_wr_zero  = wr_dec[ZERO_REG];
  assign reg_q[ZERO_REG] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    register_32 u_reg (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .enable     (wr_dec[i] & ctrl_writeEnable),
      .d          (data_writeReg),
      .q          (reg_q[i])
    );
  end

  // AND-OR select trees; exactly one decode bit is set, so no contention.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      data_readRegA = data_readRegA | (reg_q[i] & {DATA_WIDTH{rd_dec_a[i]}});
      data_readRegB = data_readRegB | (reg_q[i] & {DATA_WIDTH{rd_dec_b[i]}});
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for the register file.
module tb_regfile;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int n_compared   = 0;
  int n_mismatched = 0;

  regfile dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; samples are taken 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = idx;
    data_writeReg    = val;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    #1;
    check($sformatf("%s_A[%0d]", tag, a), data_readRegA, exp_a);
    check($sformatf("%s_B[%0d]", tag, b), data_readRegB, exp_b);
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : (32'h1000_0000 | 32'(i));
  endfunction

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    data_writeReg    = '0;
    tick();
    tick();
    ctrl_reset = 1'b0;
    read_check("por", 5'd0, 5'd31, 32'h0, 32'h0);

    // Reset clears stored data
    write_reg(5'd5, 32'hDEAD_BEEF);
    read_check("pre_rst", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    read_check("post_rst", 5'd5, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++)
      read_check("rst_sweep", 5'(i), 5'(31 - i), 32'h0, 32'h0);

    // Write r1..r31 back to back, then read both ports in opposite orders
    for (int i = 1; i < 32; i++)
      write_reg(5'(i), 32'h1000_0000 | 32'(i));
    for (int i = 0; i < 32; i++)
      read_check("wr_sweep", 5'(i), 5'(31 - i), sweep_val(i), sweep_val(31 - i));

    // r0 ignores writes; nothing else disturbed
    write_reg(5'd0, 32'hFFFF_FFFF);
    read_check("r0", 5'd0, 5'd0, 32'h0, 32'h0);
    for (int i = 1; i < 32; i++)
      read_check("r0_other", 5'(i), 5'(i), sweep_val(i), sweep_val(i));

    // Enable gating
    write_reg(5'd7, 32'hAAAA_5555);
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h1234_5678;
    tick();
    read_check("we_low", 5'd7, 5'd8, 32'hAAAA_5555, sweep_val(8));

    // Same-cycle read of the register being written: old value until the edge
    write_reg(5'd9, 32'h0000_0001);
    ctrl_readRegA    = 5'd9;
    ctrl_readRegB    = 5'd9;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'hCAFE_F00D;
    #1;
    check("same_cyc_before_A", data_readRegA, 32'h0000_0001);
    check("same_cyc_before_B", data_readRegB, 32'h0000_0001);
    tick();
    ctrl_writeEnable = 1'b0;
    read_check("same_cyc_after", 5'd9, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Reset beats a simultaneous write; next write proceeds normally
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h5555_5555;
    tick();
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    read_check("collide", 5'd3, 5'd9, 32'h0, 32'h0);
    write_reg(5'd3, 32'h0000_0077);
    read_check("post_collide", 5'd3, 5'd7, 32'h0000_0077, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry x 32-bit register file with one write port and two read ports, for the PC3 processor datapath.
- Sits directly downstream of the 5-to-32 write-address decoder: the decoder's one-hot output, gated by the write enable, selects the single register loaded on a clock edge.
- Read ports are asynchronous selects over the register outputs, addressed by two further 5-to-32 decodes.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; entries = 2**ADDR_WIDTH = 32.

Ports:
- clock  input  1  single rising-edge clock for all state.
- ctrl_reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- ctrl_writeEnable  input  1  when high, the addressed register is written at the rising edge.
- ctrl_writeReg  input  5  write register index.
- ctrl_readRegA  input  5  read port A register index.
- ctrl_readRegB  input  5  read port B register index.
- data_writeReg  input  32  write data.
- data_readRegA  output  32  contents of register ctrl_readRegA.
- data_readRegB  output  32  contents of register ctrl_readRegB.

Behaviour:
- Reset
  - ctrl_reset high at a rising edge clears all 32 registers to 32'h0 at that edge.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-sequence needs no clearing delay: after the edge every read returns 0, and writes on the next edge proceed normally.
  - There is no output register to reset. Outputs read 0 after reset because all storage is 0.
- Write
  - At a rising edge with ctrl_reset=0 and ctrl_writeEnable=1, register[ctrl_writeReg] <= data_writeReg.
  - Exactly one register is loaded, selected by the one-hot decode of ctrl_writeReg ANDed with ctrl_writeEnable.
  - Other registers hold.
  - ctrl_writeEnable=0: no register changes, whatever ctrl_writeReg and data_writeReg are.
- Register 0
  - Writes to index 0 are ignored; register 0 has no storage, or its enable is tied low.
  - data_readRegX is 32'h0 whenever ctrl_readRegX = 0.
- Read
  - Purely combinational from current register state; zero cycles of latency from an address change.
  - Each port is a 32-way one-hot select, driven by a 5-to-32 decode of its address: tri-state buffers or an AND-OR tree.
  - Exactly one source drives at a time; no X/Z for any legal address.
  - Ports A and B are independent and may address the same register.
- Same-cycle read/write
  - No bypass.
  - A read of the register being written returns the old value until the rising edge, then the new value in the following cycle.
- Width
  - Full 32-bit values are stored unmodified; no sign handling.
  - Address values 0-31 are all legal, so there are no out-of-range addresses.
- State
  - No FSM.
  - State is exactly 31 x 32 flops (registers 1-31), each with an enable and a synchronous clear.

Decomposition:
- Shared header holds the constants NUM_REGS=32, DATA_WIDTH=32, ADDR_WIDTH=5, and ZERO_REG=0.
- Reuse the existing decoder_5_32 three times: write index, read A index, read B index.
- One natural sub-module: register_32. It is a 32-bit register with inputs clock, ctrl_reset (synchronous clear) and enable, plus data in and data out. It is instantiated 31 times via a generate loop.
- Read selection is inline in regfile: generate loop of tri-state buffers or AND-OR reduction.

Test Plan:
- Reset: write 32'hDEADBEEF to r5, assert ctrl_reset for one edge -> data_readRegA(r5)=0. Sweep all 32 indices on both ports -> all read 0.
- Write/readback: with writeEnable=1, write value (32'h1000_0000 | i) to r1..r31 on consecutive edges -> port A sweep returns each value, port B sweep matches, no aliasing.
- r0: write 32'hFFFFFFFF to r0 -> both ports read r0 = 0; r1..r31 unchanged.
- Enable gating: writeEnable=0 with writeReg=7, data 32'h12345678 -> r7 keeps its prior value 32'hAAAA5555.
- Same-cycle: readRegA=9 and write 32'hCAFEF00D to r9, where r9 previously held 32'h1 -> port A reads 32'h1 before the edge and 32'hCAFEF00D after it. readRegA=readRegB=9 -> both ports equal.
- Reset vs write collision: ctrl_reset=1 and writeEnable=1 to r3 on the same edge -> r3=0. Next edge with reset low writes 32'h77 -> r3=32'h77.
